ex_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the 5-stage MIPS pipeline. It consumes the forwarded EX-stage operands that come out of the ID/EX pipeline register, runs MULT/MULTU/DIV/DIVU over 34 cycles, and serves MTHI/MTLO writes. It exports `busy` to the hazard unit, which stalls IF/ID and flushes ID/EX while a dependent instruction waits.

---
 rtl/ex_muldiv.sv | 128 ++++++++++++
 tb/tb_ex_muldiv.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the EX stage.
// Operands are reduced to magnitudes. The core runs 32 unsigned iterations, and signs are applied in FIX.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        HiWriteE,
  input  logic        LoWriteE,
  output logic        busy,
  output logic [31:0] HiE,
  output logic [31:0] LoE
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        dz;
  logic        isDiv;
  logic        negRes;
  logic        negRem;
  logic [31:0] opB;
  logic [63:0] acc;

  function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
    return (isSigned && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  logic        opSigned;
  logic        opIsDiv;
  logic [32:0] mulSum;
  logic [64:0] divShift;
  logic [33:0] divDiff;
  logic        divGe;
  logic [63:0] accNext;
  logic [63:0] prodFix;
  logic [31:0] quotFix;
  logic [31:0] remFix;

  assign opSigned = ~op[0];
  assign opIsDiv  = op[1];
  assign busy     = (state != IDLE);

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opB : 32'd0)};
    divShift = {acc, 1'b0};
    divDiff  = {1'b0, divShift[64:32]} - {2'b00, opB};
    // A successful trial subtract always leaves a difference below the divisor, so bits 33:32 are clear
    divGe    = (divDiff[33:32] == 2'b00);
    if (isDiv)
      accNext = divGe ? {divDiff[31:0], divShift[31:1], 1'b1} : divShift[63:0];
    else
      accNext = {mulSum, acc[31:1]};
    prodFix = neg64(acc, negRes);
    quotFix = neg32(acc[31:0], negRes);
    remFix  = neg32(acc[63:32], negRem);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      dz     <= 1'b0;
      isDiv  <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      opB    <= 32'd0;
      acc    <= 64'd0;
      HiE    <= 32'd0;
      LoE    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            isDiv  <= opIsDiv;
            negRes <= opSigned & (SrcAE[31] ^ SrcBE[31]);
            negRem <= opSigned & opIsDiv & SrcAE[31];
            opB    <= absVal(SrcBE, opSigned);
            acc    <= {32'd0, absVal(SrcAE, opSigned)};
            cnt    <= 5'd0;
            if (opIsDiv && (SrcBE == 32'd0)) begin
              dz    <= 1'b1;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              state <= CALC;
            end
          end else begin
            if (HiWriteE) HiE <= SrcAE;
            if (LoWriteE) LoE <= SrcAE;
          end
        end
        CALC: begin
          acc <= accNext;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (!dz) begin
            if (isDiv) begin
              LoE <= quotFix;
              HiE <= remFix;
            end else begin
              HiE <= prodFix[63:32];
              LoE <= prodFix[31:0];
            end
          end
          dz    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: the driver pushes model results, and a monitor checks each completion.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        HiWriteE;
  logic        LoWriteE;
  logic        busy;
  logic [31:0] HiE;
  logic [31:0] LoE;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .HiWriteE(HiWriteE), .LoWriteE(LoWriteE),
    .busy(busy), .HiE(HiE), .LoE(LoE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] prevHi;
    logic [31:0] prevLo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        monE;
  int          checks  = 0;
  int          errors  = 0;
  int          busyCnt = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic; division truncates toward zero
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    longint sa, sb, r;
    longint unsigned ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.prevHi = h; e.prevLo = l; e.hi = h; e.lo = l; e.cyc = 33;
    case (o)
      2'd0: begin r = sa * sb; e.hi = r[63:32]; e.lo = r[31:0]; end
      2'd1: begin ur = ua * ub; e.hi = ur[63:32]; e.lo = ur[31:0]; end
      2'd2: begin
        if (b == 32'd0) e.cyc = 1;
        else begin r = sa / sb; e.lo = r[31:0]; r = sa % sb; e.hi = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) e.cyc = 1;
        else begin ur = ua / ub; e.lo = ur[31:0]; ur = ua % ub; e.hi = ur[31:0]; end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      busyCnt = 0;
    end else if (busy) begin
      busyCnt++;
      if (busyCnt == 16 && q.size() > 0) begin
        check("stableHi", HiE, q[0].prevHi);
        check("stableLo", LoE, q[0].prevLo);
      end
    end else if (busyCnt > 0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedDone: got completion expected none");
      end else begin
        monE = q.pop_front();
        check("resultHi", HiE, monE.hi);
        check("resultLo", LoE, monE.lo);
        check("busyCycles", busyCnt, monE.cyc);
      end
      busyCnt = 0;
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL waitIdle: got busy=1 expected busy=0 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic wr);
    exp_t e;
    waitIdle();
    e = model(o, a, b, mHi, mLo);
    q.push_back(e);
    mHi = e.hi;
    mLo = e.lo;
    start = 1'b1; op = o; SrcAE = a; SrcBE = b; HiWriteE = wr;
    @(posedge clk); #1;
    start = 1'b0; HiWriteE = 1'b0;
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] val);
    waitIdle();
    HiWriteE = hw; LoWriteE = lw; SrcAE = val;
    @(posedge clk); #1;
    HiWriteE = 1'b0; LoWriteE = 1'b0;
    if (hw) mHi = val;
    if (lw) mLo = val;
    check("mtHi", HiE, mHi);
    check("mtLo", LoE, mLo);
  endtask

  initial begin
    exp_t e1, e2;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'd0; SrcAE = 32'd0; SrcBE = 32'd0;
    HiWriteE = 1'b0; LoWriteE = 1'b0;
    #12 rst = 1'b0;
    check("resetBusy", {31'd0, busy}, 32'd0);
    check("resetHi", HiE, 32'd0);
    check("resetLo", LoE, 32'd0);
    @(posedge clk); #1;

    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    waitIdle();

    // MULT with start held high; the queued DIV operands are taken at edge 34
    e1 = model(2'd0, 32'hFFFFFFFD, 32'd5, mHi, mLo);
    e2 = model(2'd2, 32'hFFFFFFF9, 32'd2, e1.hi, e1.lo);
    q.push_back(e1);
    q.push_back(e2);
    mHi = e2.hi; mLo = e2.lo;
    start = 1'b1; op = 2'd0; SrcAE = 32'hFFFFFFFD; SrcBE = 32'd5;
    @(posedge clk); #1;
    op = 2'd2; SrcAE = 32'hFFFFFFF9; SrcBE = 32'd2;
    waitIdle();
    @(posedge clk); #1;
    check("b2bAccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    waitIdle();

    issue(2'd3, 32'd100, 32'd7, 1'b0);
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    mt(1'b1, 1'b0, 32'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    issue(2'd2, 32'd9, 32'd0, 1'b0);
    issue(2'd3, 32'd50, 32'd0, 1'b0);
    issue(2'd1, 32'd3, 32'd4, 1'b0);
    mt(1'b1, 1'b1, 32'hA5A5A5A5);

    issue(2'd1, 32'd2, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    HiWriteE = 1'b1; SrcAE = 32'hDEAD; start = 1'b1; op = 2'd0;
    @(posedge clk); #1;
    HiWriteE = 1'b0; start = 1'b0;
    waitIdle();
    mt(1'b0, 1'b1, 32'd7);

    e1.prevHi = mHi;
    issue(2'd1, 32'd4, 32'd5, 1'b1);
    check("startWinsHi", HiE, e1.prevHi);
    waitIdle();

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = $urandom_range(1, 15);
        default: ;
      endcase
      issue(2'($urandom_range(0, 3)), ra, rb, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    waitIdle();

    // Asynchronous reset just after CALC iteration 15
    issue(2'd1, 32'd5, 32'd5, 1'b0);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midResetBusy", {31'd0, busy}, 32'd0);
    check("midResetHi", HiE, 32'd0);
    check("midResetLo", LoE, 32'd0);
    q.delete();
    mHi = 32'd0; mLo = 32'd0;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    issue(2'd1, 32'd5, 32'd5, 1'b0);
    waitIdle();
    @(negedge clk); #1;

    check("queueEmpty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
